// File: rtl/vid_pkg.sv
// Shared definitions for the video-to-AXI4-Stream bridge: pixel width,
// FIFO entry field positions and the vsync leading-edge helper.
package vid_pkg;

  localparam int PIX_W   = 24;
  localparam int EOL_BIT = PIX_W;
  localparam int SOF_BIT = PIX_W + 1;

  // Field positions for an arbitrary pixel width: entry = {sof, eol, data}.
  function automatic int eol_pos(input int data_w);
    return data_w;
  endfunction

  function automatic int sof_pos(input int data_w);
    return data_w + 1;
  endfunction

  // True on the cycle vs enters its active level.
  function automatic logic vs_lead(input logic vs_prev, input logic vs_cur, input logic pol);
    return (vs_cur == pol) && (vs_prev != pol);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; a write is accepted while full
// if a read happens in the same cycle.
module sync_fifo_fwft #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_wr, do_rd;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_rd    = rd_en && !empty;
    do_wr    = wr_en && (!full || do_rd);
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd};
    rd_data  = mem_q[rd_ptr_q[AW-1:0]];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/vid_rgb_to_axis.sv
// Parallel video (vs/hs/de/rgb) to AXI4-Stream bridge with one-pixel lookahead
// for tlast, SOF marking, FIFO buffering and per-frame overflow drop.
module vid_rgb_to_axis
  import vid_pkg::*;
#(
  parameter int   DATA_W     = PIX_W,
  parameter int   FIFO_DEPTH = 16,
  parameter logic VS_POL     = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              vs_i,
  input  logic              hs_i,
  input  logic              de_i,
  input  logic [DATA_W-1:0] rgb_i,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tuser,
  output logic              m_axis_tlast,
  output logic              ovf_o,
  output logic [15:0]       frame_cnt_o
);

  localparam int EW    = DATA_W + 2;
  localparam int SOF_B = sof_pos(DATA_W);
  localparam int EOL_B = eol_pos(DATA_W);

  logic              vs_prev_q, vs_prev_d;
  logic              held_q, held_d;
  logic              hold_sof_q, hold_sof_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic              sof_pending_q, sof_pending_d;
  logic              drop_q, drop_d;
  logic              ovf_q, ovf_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  logic              fifo_wr_en, fifo_full, fifo_empty, fifo_pop;
  logic [EW-1:0]     fifo_wr_data, fifo_rd_data;
  logic              vs_edge, lose, load;
  logic              hs_unused;

  // Line boundaries come from de_i; hs_i carries no information we need.
  assign hs_unused = hs_i;

  assign vs_edge  = vs_lead(vs_prev_q, vs_i, VS_POL);
  assign fifo_pop = !fifo_empty && m_axis_tready;

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    vs_prev_d     = vs_i;
    held_d        = held_q;
    hold_sof_d    = hold_sof_q;
    hold_data_d   = hold_data_q;
    sof_pending_d = sof_pending_q;
    drop_d        = drop_q;
    ovf_d         = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    fifo_wr_en    = 1'b0;
    fifo_wr_data  = {hold_sof_q, ~de_i, hold_data_q};
    lose          = 1'b0;
    load          = 1'b0;

    if (vs_edge) begin
      // New frame: forget any held pixel and any drop in progress.
      sof_pending_d = 1'b1;
      drop_d        = 1'b0;
      held_d        = 1'b0;
      load          = de_i;
    end else if (!drop_q) begin
      if (held_q) begin
        if (fifo_full && !fifo_pop) begin
          lose   = 1'b1;
          drop_d = 1'b1;
          ovf_d  = 1'b1;
          held_d = 1'b0;
        end else begin
          fifo_wr_en = 1'b1;
          held_d     = 1'b0;
          if (hold_sof_q) frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      load = de_i && !lose;
    end

    if (load) begin
      held_d        = 1'b1;
      hold_sof_d    = vs_edge | sof_pending_q;
      hold_data_d   = rgb_i;
      sof_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vs_prev_q     <= ~VS_POL;
      held_q        <= 1'b0;
      hold_sof_q    <= 1'b0;
      hold_data_q   <= '0;
      sof_pending_q <= 1'b0;
      drop_q        <= 1'b0;
      ovf_q         <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      vs_prev_q     <= vs_prev_d;
      held_q        <= held_d;
      hold_sof_q    <= hold_sof_d;
      hold_data_q   <= hold_data_d;
      sof_pending_q <= sof_pending_d;
      drop_q        <= drop_d;
      ovf_q         <= ovf_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_en   (fifo_wr_en),
    .wr_data (fifo_wr_data),
    .full    (fifo_full),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty)
  );

  // Gate the head entry so an empty FIFO presents all-zero AXIS outputs.
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : fifo_rd_data[DATA_W-1:0];
  assign m_axis_tuser  = !fifo_empty && fifo_rd_data[SOF_B];
  assign m_axis_tlast  = !fifo_empty && fifo_rd_data[EOL_B];
  assign ovf_o         = ovf_q;
  assign frame_cnt_o   = frame_cnt_q;

endmodule
